mem_port: RTL and testbench

//  Load/store unit between the core datapath memory outputs and the external word-wide memory bus.

---
 rtl/mem_port_pkg.sv | 28 ++
 rtl/mem_align.sv | 42 ++++
 rtl/mem_port.sv | 158 +++++++++++++++
 tb/tb_mem_port.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_pkg.sv
// rtl/mem_port_pkg.sv - shared types for the load/store port and its lane aligner
package mem_port_pkg;

  typedef logic [31:0] word_t;
  typedef logic [29:0] pc_t;
  typedef logic [3:0]  be_t;

  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_addr_t;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} mport_state_t;

  // Access width in bytes; 0 marks an unsupported funct3 code.
  function automatic logic [2:0] size_bytes(mem_addr_t s);
    case (s)
      MEM_B, MEM_BU: size_bytes = 3'd1;
      MEM_H, MEM_HU: size_bytes = 3'd2;
      MEM_W:         size_bytes = 3'd4;
      default:       size_bytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// rtl/mem_align.sv - byte-lane enables, store data shifting and load merge/extend
module mem_align
  import mem_port_pkg::*;
(
  input  logic [1:0] off,
  input  mem_addr_t  size,
  input  word_t      wdata,
  input  word_t      lo,
  input  word_t      hi,
  output be_t        be0,
  output be_t        be1,
  output word_t      wd0,
  output word_t      wd1,
  output word_t      load_val
);

  logic [7:0]  be8;
  logic [63:0] wd64;
  logic [31:0] rd;
  logic [2:0]  n;

  always_comb begin
    n    = size_bytes(size);
    be8  = ((8'd1 << n) - 8'd1) << off;
    wd64 = {32'b0, wdata} << {off, 3'b000};
    // The two beats form one 64-bit window; shift the addressed bytes down to lane 0.
    rd   = 32'({hi, lo} >> {off, 3'b000});
    case (size)
      MEM_B:   load_val = {{24{rd[7]}}, rd[7:0]};
      MEM_H:   load_val = {{16{rd[15]}}, rd[15:0]};
      MEM_BU:  load_val = {24'b0, rd[7:0]};
      MEM_HU:  load_val = {16'b0, rd[15:0]};
      default: load_val = rd;
    endcase
  end

  assign be0 = be8[3:0];
  assign be1 = be8[7:4];
  assign wd0 = wd64[31:0];
  assign wd1 = wd64[63:32];

endmodule

// File: rtl/mem_port.sv
// rtl/mem_port.sv - load/store unit splitting datapath accesses into aligned bus beats
module mem_port
  import mem_port_pkg::*;
#(
  parameter bit          SPLIT_EN = 1'b1,
  parameter int unsigned TIMEOUT  = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [2:0]  size,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [29:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  mport_state_t state_q, state_d;
  logic         we_q, we_d;
  word_t        addr_q, addr_d;
  mem_addr_t    size_q, size_d;
  word_t        wdata_q, wdata_d;
  word_t        lo_q, lo_d;
  logic [15:0]  wcnt_q, wcnt_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         err_q, err_d;
  word_t        rdata_q, rdata_d;

  logic [2:0] n_in;
  logic       cross_in;
  logic       split;
  logic       ack_fin;
  be_t        be0, be1;
  word_t      wd0, wd1, load_val, lo_sel, hi_sel;

  mem_align u_align (
    .off      (addr_q[1:0]),
    .size     (size_q),
    .wdata    (wdata_q),
    .lo       (lo_sel),
    .hi       (hi_sel),
    .be0      (be0),
    .be1      (be1),
    .wd0      (wd0),
    .wd1      (wd1),
    .load_val (load_val)
  );

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    addr_d   = addr_q;
    size_d   = size_q;
    wdata_d  = wdata_q;
    lo_d     = lo_q;
    wcnt_d   = wcnt_q;
    rdata_d  = rdata_q;
    err_d    = 1'b0;

    n_in     = size_bytes(mem_addr_t'(size));
    cross_in = ({1'b0, addr[1:0]} + n_in) > 3'd4;
    split    = ({1'b0, addr_q[1:0]} + size_bytes(size_q)) > 3'd4;
    ack_fin  = bus_ack && ((state_q == BEAT1) || (state_q == BEAT0 && !split));
    // On the last beat the current bus word completes the merge window.
    lo_sel   = (state_q == BEAT0) ? bus_rdata : lo_q;
    hi_sel   = (state_q == BEAT1) ? bus_rdata : 32'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          we_d    = we;
          addr_d  = addr;
          size_d  = mem_addr_t'(size);
          wdata_d = wdata;
          wcnt_d  = 16'd0;
          if (n_in == 3'd0 || (cross_in && !SPLIT_EN)) begin
            state_d = RESP;
            err_d   = 1'b1;
          end else begin
            state_d = BEAT0;
          end
        end
      end
      BEAT0, BEAT1: begin
        if (bus_ack) begin
          wcnt_d = 16'd0;
          if (state_q == BEAT0) lo_d = bus_rdata;
          state_d = (state_q == BEAT0 && split) ? BEAT1 : RESP;
        end else if (TIMEOUT != 0 && wcnt_q == TO_LAST) begin
          state_d = RESP;
          err_d   = 1'b1;
        end else begin
          wcnt_d = wcnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (ack_fin && !we_q) rdata_d = load_val;
    done_d = (state_d == RESP);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= 32'b0;
      size_q  <= MEM_B;
      wdata_q <= 32'b0;
      lo_q    <= 32'b0;
      wcnt_q  <= 16'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      lo_q    <= lo_d;
      wcnt_q  <= wcnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;
  assign rdata = rdata_q;

  always_comb begin
    bus_req   = (state_q == BEAT0) || (state_q == BEAT1);
    bus_we    = bus_req && we_q;
    bus_addr  = addr_q[31:2] + ((state_q == BEAT1) ? 30'd1 : 30'd0);
    bus_be    = (state_q == BEAT0) ? be0 : (state_q == BEAT1) ? be1 : 4'b0;
    bus_wdata = (state_q == BEAT1) ? wd1 : wd0;
  end

endmodule

// File: tb/tb_mem_port.sv
// tb/tb_mem_port.sv - scoreboard bench for mem_port
module tb_mem_port;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          due;
  } exp_t;

  typedef struct {
    logic        we;
    logic [29:0] waddr;
    logic [3:0]  be;
    logic [31:0] wd;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  logic start_a, start_b, we;
  logic [31:0] addr, wdata;
  logic [2:0]  size;

  logic a_busy, a_done, a_err, a_req, a_we, a_ack, a_force;
  logic [31:0] a_rdata, a_wd, a_rd;
  logic [29:0] a_addr;
  logic [3:0]  a_be;
  logic b_busy, b_done, b_err, b_req, b_we, b_ack;
  logic [31:0] b_rdata, b_wd, b_rd;
  logic [29:0] b_addr;
  logic [3:0]  b_be;

  int n_chk = 0, n_fail = 0, cyc = 0, a_waits = 0, a_wc = 0;
  logic [31:0] last_rd = 32'b0;
  exp_t  exp_q[$];
  beat_t beat_q[$];
  logic [31:0] mem [logic [29:0]];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port #(.SPLIT_EN(1'b1), .TIMEOUT(0)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .we(we), .addr(addr), .size(size), .wdata(wdata),
    .busy(a_busy), .done(a_done), .err(a_err), .rdata(a_rdata),
    .bus_req(a_req), .bus_we(a_we), .bus_addr(a_addr), .bus_be(a_be), .bus_wdata(a_wd),
    .bus_ack(a_ack), .bus_rdata(a_rd));

  mem_port #(.SPLIT_EN(1'b0), .TIMEOUT(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .we(we), .addr(addr), .size(size), .wdata(wdata),
    .busy(b_busy), .done(b_done), .err(b_err), .rdata(b_rdata),
    .bus_req(b_req), .bus_we(b_we), .bus_addr(b_addr), .bus_be(b_be), .bus_wdata(b_wd),
    .bus_ack(b_ack), .bus_rdata(b_rd));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [29:0] a);
    return mem.exists(a) ? mem[a] : 32'b0;
  endfunction

  function automatic logic [31:0] lanes(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  // Bus model for dut_a: ack after a_waits wait cycles, check each beat against the scoreboard.
  always @(negedge clk) begin
    a_ack = 1'b0;
    if (a_force) begin
      a_ack = 1'b1;
    end else if (a_req) begin
      if (a_wc >= a_waits) begin
        beat_t bt;
        a_ack = 1'b1;
        a_rd  = mem_rd(a_addr);
        a_wc  = 0;
        if (beat_q.size() == 0) begin
          chk("unexpected_beat", {34'b0, a_addr}, 64'hFFFF_FFFF);
        end else begin
          bt = beat_q.pop_front();
          chk("beat_addr", {34'b0, a_addr}, {34'b0, bt.waddr});
          chk("beat_be", {60'b0, a_be}, {60'b0, bt.be});
          chk("beat_we", {63'b0, a_we}, {63'b0, bt.we});
          if (bt.we) chk("beat_wdata", {32'b0, a_wd & lanes(bt.be)}, {32'b0, bt.wd & lanes(bt.be)});
        end
        if (a_we) mem[a_addr] = (mem_rd(a_addr) & ~lanes(a_be)) | (a_wd & lanes(a_be));
      end else begin
        a_wc++;
      end
    end else begin
      a_wc = 0;
    end
  end

  always @(negedge clk) begin
    if (a_done) begin
      if (exp_q.size() == 0) begin
        chk("spurious_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("err", {63'b0, a_err}, {63'b0, e.err});
        chk("rdata", {32'b0, a_rdata}, {32'b0, e.rdata});
        chk("latency", 64'(cyc), 64'(e.due));
      end
    end
  end

  // Builds the expected beats and result byte by byte, then pulses start_a for one cycle.
  task automatic a_issue(input logic w, input logic [31:0] ad, input logic [2:0] sz, input logic [31:0] wd);
    int n, k, nb;
    logic bad;
    logic [3:0]  be_e[2];
    logic [31:0] wv[2];
    logic [7:0]  by[4];
    logic [31:0] ba, word;
    exp_t  e;
    beat_t bt;
    @(negedge clk);
    bad = (sz == 3'b011) || (sz == 3'b110) || (sz == 3'b111);
    n = (sz[1:0] == 2'b00) ? 1 : (sz[1:0] == 2'b01) ? 2 : 4;
    be_e[0] = 4'b0; be_e[1] = 4'b0; wv[0] = 32'b0; wv[1] = 32'b0;
    for (int i = 0; i < 4; i++) by[i] = 8'b0;
    for (int i = 0; i < n; i++) begin
      ba = ad + 32'(i);
      k = (ba[31:2] == ad[31:2]) ? 0 : 1;
      be_e[k][ba[1:0]] = 1'b1;
      wv[k][8*ba[1:0] +: 8] = wd[8*i +: 8];
      word = mem_rd(ba[31:2]);
      by[i] = word[8*ba[1:0] +: 8];
    end
    nb = (be_e[1] != 4'b0) ? 2 : 1;
    if (!bad) begin
      for (int j = 0; j < nb; j++) begin
        bt.we = w; bt.waddr = ad[31:2] + 30'(j); bt.be = be_e[j]; bt.wd = wv[j];
        beat_q.push_back(bt);
      end
      if (!w) begin
        case (sz)
          3'b000:  last_rd = {{24{by[0][7]}}, by[0]};
          3'b001:  last_rd = {{16{by[1][7]}}, by[1], by[0]};
          3'b100:  last_rd = {24'b0, by[0]};
          3'b101:  last_rd = {16'b0, by[1], by[0]};
          default: last_rd = {by[3], by[2], by[1], by[0]};
        endcase
      end
    end
    e.err = bad; e.rdata = last_rd;
    e.due = bad ? cyc + 1 : cyc + 1 + nb * (1 + a_waits);
    exp_q.push_back(e);
    we = w; addr = ad; size = sz; wdata = wd; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic a_wait();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      chk("wait_bound", 64'd1, 64'd0);
      exp_q.delete();
      beat_q.delete();
    end
  endtask

  task automatic a_run(input logic w, input logic [31:0] ad, input logic [2:0] sz, input logic [31:0] wd);
    a_issue(w, ad, sz, wd);
    a_wait();
  endtask

  // dut_b never sees an ack: checks error latency and how long bus_req stays up.
  task automatic b_run(input string tag, input logic [31:0] ad, input logic [2:0] sz, input int lat, input int reqs);
    int t0, nreq;
    logic seen;
    @(negedge clk);
    we = 1'b0; addr = ad; size = sz; wdata = 32'b0; start_b = 1'b1;
    t0 = cyc; nreq = 0; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      start_b = 1'b0;
      if (b_done) begin
        seen = 1'b1;
        chk({tag, "_lat"}, 64'(cyc - t0), 64'(lat));
        chk({tag, "_err"}, {63'b0, b_err}, 64'd1);
        chk({tag, "_req_drop"}, {63'b0, b_req}, 64'd0);
        chk({tag, "_rdata"}, {32'b0, b_rdata}, 64'd0);
      end else if (b_req) begin
        nreq++;
      end
    end
    chk({tag, "_done_seen"}, {63'b0, seen}, 64'd1);
    chk({tag, "_req_cycles"}, 64'(nreq), 64'(reqs));
  endtask

  initial begin
    int ndone;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; we = 1'b0; addr = 32'b0; size = 3'b010;
    wdata = 32'b0; a_ack = 1'b0; a_force = 1'b0; a_rd = 32'b0; b_ack = 1'b0; b_rd = 32'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'b0, a_busy}, 64'd0);
    chk("rst_done", {63'b0, a_done}, 64'd0);
    chk("rst_err", {63'b0, a_err}, 64'd0);
    chk("rst_req", {63'b0, a_req}, 64'd0);
    chk("rst_we", {63'b0, a_we}, 64'd0);
    chk("rst_be", {60'b0, a_be}, 64'd0);
    chk("rst_rdata", {32'b0, a_rdata}, 64'd0);
    rst = 1'b0;

    mem[30'h40] = 32'hDEADBEEF;
    a_run(1'b0, 32'h100, 3'b010, 32'h0);
    mem[30'h40] = 32'h80112233;
    a_run(1'b0, 32'h103, 3'b000, 32'h0);
    a_run(1'b0, 32'h103, 3'b100, 32'h0);
    a_run(1'b1, 32'h203, 3'b001, 32'h0000ABCD);
    a_run(1'b0, 32'h203, 3'b101, 32'h0);
    mem[30'h40] = 32'h44332211;
    mem[30'h41] = 32'h88776655;
    a_run(1'b0, 32'h102, 3'b010, 32'h0);
    a_run(1'b0, 32'h102, 3'b001, 32'h0);
    a_run(1'b0, 32'h106, 3'b001, 32'h0);
    a_waits = 2;
    a_run(1'b0, 32'h102, 3'b010, 32'h0);
    a_run(1'b0, 32'h101, 3'b000, 32'h0);
    a_waits = 0;
    mem[30'h3FFFFFFF] = 32'hAABBCCDD;
    mem[30'h0] = 32'h11223344;
    a_run(1'b0, 32'hFFFFFFFE, 3'b010, 32'h0);
    a_run(1'b1, 32'h101, 3'b000, 32'h5A5A5A77);
    a_run(1'b1, 32'h300, 3'b010, 32'h12345678);
    a_run(1'b0, 32'h300, 3'b010, 32'h0);
    a_run(1'b0, 32'h101, 3'b010, 32'h0);
    a_run(1'b1, 32'h10F, 3'b001, 32'hFFFF9876);
    a_run(1'b0, 32'h10E, 3'b010, 32'h0);
    a_run(1'b0, 32'h100, 3'b011, 32'h0);
    a_run(1'b0, 32'h100, 3'b110, 32'h0);

    // start while busy must not launch a second access
    a_waits = 3;
    a_issue(1'b0, 32'h100, 3'b010, 32'h0);
    addr = 32'h200; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    a_wait();

    // reset in the middle of a waited beat, then a stray ack
    a_waits = 20;
    a_issue(1'b0, 32'h100, 3'b010, 32'h0);
    repeat (2) @(negedge clk);
    chk("pre_rst_req", {63'b0, a_req}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("post_rst_req", {63'b0, a_req}, 64'd0);
    chk("post_rst_busy", {63'b0, a_busy}, 64'd0);
    exp_q.delete();
    beat_q.delete();
    a_force = 1'b1;
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      a_force = 1'b0;
      if (a_done) ndone++;
    end
    chk("no_done_after_rst", 64'(ndone), 64'd0);
    a_waits = 0;
    last_rd = a_rdata;
    a_run(1'b0, 32'h300, 3'b010, 32'h0);

    b_run("b_misalign", 32'h102, 3'b010, 1, 0);
    b_run("b_badsize", 32'h100, 3'b011, 1, 0);
    b_run("b_timeout", 32'h100, 3'b010, 5, 4);

    chk("beats_left", 64'(beat_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
